// File: rtl/bp_io_lce_responder.sv
// I/O LCE responder: turns uncached LCE requests into I/O memory commands and
// turns I/O memory responses back into LCE commands. Each direction has a
// single-entry output buffer. A credit counter tracks outstanding I/O
// transactions so that responses nobody asked for can be dropped.

typedef enum int {
    e_bp_default_cfg    = 0,
    e_bp_wide_block_cfg = 1
} bp_params_e;

localparam int io_noc_max_credits_p = 16;

module bp_io_lce_responder
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int els_p = io_noc_max_credits_p,
    localparam int cce_id_width_p = 6,
    localparam int lce_id_width_p = 6,
    localparam int paddr_width_p = 40,
    localparam int cce_block_width_p = (bp_params_p == e_bp_wide_block_cfg) ? 512 : 64,
    localparam int lce_req_header_width_lp = 4 + paddr_width_p + 3 + cce_id_width_p + lce_id_width_p,
    localparam int mem_header_width_lp = 4 + 4 + paddr_width_p + 3 + lce_id_width_p + 3 + 3,
    localparam int lce_cmd_header_width_lp = 4 + paddr_width_p + 3 + lce_id_width_p + cce_id_width_p + 3 + 3
)
(
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [cce_id_width_p-1:0]          cce_id_i,
    input  logic [lce_req_header_width_lp-1:0] lce_req_header_i,
    input  logic [cce_block_width_p-1:0]       lce_req_data_i,
    input  logic                               lce_req_v_i,
    output logic                               lce_req_yumi_o,
    output logic [mem_header_width_lp-1:0]     io_cmd_header_o,
    output logic [cce_block_width_p-1:0]       io_cmd_data_o,
    output logic                               io_cmd_v_o,
    output logic                               io_cmd_last_o,
    input  logic                               io_cmd_ready_and_i,
    input  logic [mem_header_width_lp-1:0]     io_resp_header_i,
    input  logic [cce_block_width_p-1:0]       io_resp_data_i,
    input  logic                               io_resp_v_i,
    input  logic                               io_resp_last_i,
    output logic                               io_resp_yumi_o,
    output logic [lce_cmd_header_width_lp-1:0] lce_cmd_header_o,
    output logic [cce_block_width_p-1:0]       lce_cmd_data_o,
    output logic                               lce_cmd_v_o,
    input  logic                               lce_cmd_ready_and_i,
    output logic                               error_o
);

    localparam logic [3:0] e_bedrock_req_uc_rd     = 4'd2;
    localparam logic [3:0] e_bedrock_req_uc_wr     = 4'd3;
    localparam logic [3:0] e_bedrock_mem_uc_rd     = 4'd2;
    localparam logic [3:0] e_bedrock_mem_uc_wr     = 4'd3;
    localparam logic [3:0] e_bedrock_cmd_uc_data   = 4'd7;
    localparam logic [3:0] e_bedrock_cmd_uc_st_done = 4'd8;

    localparam int creditWidthLp = $clog2(els_p + 1);
    localparam logic [creditWidthLp-1:0] maxCreditsLp = creditWidthLp'(els_p);
    localparam logic [creditWidthLp-1:0] oneCreditLp = creditWidthLp'(1);

    typedef struct packed {
        logic [cce_id_width_p-1:0] dst_id;
        logic [lce_id_width_p-1:0] src_id;
    } lceReqPayload_s;

    typedef struct packed {
        lceReqPayload_s            payload;
        logic [2:0]                size;
        logic [paddr_width_p-1:0]  addr;
        logic [3:0]                msg_type;
    } lceReqHeader_s;

    typedef struct packed {
        logic [lce_id_width_p-1:0] lce_id;
        logic [2:0]                way_id;
        logic [2:0]                state;
    } memPayload_s;

    typedef struct packed {
        memPayload_s               payload;
        logic [2:0]                size;
        logic [paddr_width_p-1:0]  addr;
        logic [3:0]                subop;
        logic [3:0]                msg_type;
    } memHeader_s;

    typedef struct packed {
        logic [lce_id_width_p-1:0] dst_id;
        logic [cce_id_width_p-1:0] src_id;
        logic [2:0]                way_id;
        logic [2:0]                state;
    } lceCmdPayload_s;

    typedef struct packed {
        lceCmdPayload_s            payload;
        logic [2:0]                size;
        logic [paddr_width_p-1:0]  addr;
        logic [3:0]                msg_type;
    } lceCmdHeader_s;

    typedef enum logic {eEmpty, eFull} slotState_e;

    slotState_e cmdState_q, cmdState_d;
    slotState_e respState_q, respState_d;

    lceReqHeader_s reqHeader;
    memHeader_s    respHeader;
    memHeader_s    cmdHeader_q, cmdHeader_d;
    lceCmdHeader_s lceCmdHeader_q, lceCmdHeader_d;
    logic [cce_block_width_p-1:0] cmdData_q, lceCmdData_q;
    logic [creditWidthLp-1:0] credit_q, credit_d;
    logic error_q;

    logic cmdDrain, respDrain, reqIsUc, reqAccept, cmdLoad;
    logic respAccept, respHasCredit, respLoad, errorEvent;
    logic unusedBits;

    assign reqHeader  = lce_req_header_i;
    assign respHeader = io_resp_header_i;

    // A slot can take a new entry when it is empty or hands its entry off this cycle.
    assign cmdDrain  = (cmdState_q == eFull) && io_cmd_ready_and_i;
    assign respDrain = (respState_q == eFull) && lce_cmd_ready_and_i;

    // A returning LCE command frees a credit, so a request waiting at the limit
    // may go in the same cycle.
    assign reqIsUc   = (reqHeader.msg_type == e_bedrock_req_uc_rd)
                    || (reqHeader.msg_type == e_bedrock_req_uc_wr);
    assign reqAccept = reset_n_i && lce_req_v_i
                    && ((cmdState_q == eEmpty) || cmdDrain)
                    && ((credit_q < maxCreditsLp) || respDrain);
    assign cmdLoad   = reqAccept && reqIsUc;

    // The credit being returned this cycle already belongs to the command leaving
    // the slot, so it cannot also cover a newly arriving response.
    assign respAccept    = reset_n_i && io_resp_v_i && ((respState_q == eEmpty) || respDrain);
    assign respHasCredit = respDrain ? (credit_q > oneCreditLp) : (credit_q != '0);
    assign respLoad      = respAccept && respHasCredit;

    assign errorEvent = (reqAccept && !reqIsUc) || (respAccept && !respLoad);

    assign lce_req_yumi_o   = reqAccept;
    assign io_resp_yumi_o   = respAccept;
    assign io_cmd_header_o  = cmdHeader_q;
    assign io_cmd_data_o    = cmdData_q;
    assign lce_cmd_header_o = lceCmdHeader_q;
    assign lce_cmd_data_o   = lceCmdData_q;
    assign error_o          = error_q;

    assign unusedBits = ^{reqHeader.payload.dst_id, respHeader.subop,
                          respHeader.payload.way_id, respHeader.payload.state, io_resp_last_i};

    // Occupancy state of both single-entry slots.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmdState_q  <= eEmpty;
            respState_q <= eEmpty;
        end else begin
            cmdState_q  <= cmdState_d;
            respState_q <= respState_d;
        end
    end

    // Fill wins over drain so a slot can turn over every cycle.
    always_comb begin
        cmdState_d  = cmdState_q;
        respState_d = respState_q;
        if (cmdLoad) begin
            cmdState_d = eFull;
        end else if (cmdDrain) begin
            cmdState_d = eEmpty;
        end
        if (respLoad) begin
            respState_d = eFull;
        end else if (respDrain) begin
            respState_d = eEmpty;
        end
    end

    // Valids come straight from slot occupancy; every transfer is a single beat.
    always_comb begin
        io_cmd_v_o    = (cmdState_q == eFull);
        io_cmd_last_o = (cmdState_q == eFull);
        lce_cmd_v_o   = (respState_q == eFull);
    end

    // Translate an uncached LCE request and an I/O response into their outgoing headers.
    always_comb begin
        cmdHeader_d = '0;
        cmdHeader_d.msg_type = (reqHeader.msg_type == e_bedrock_req_uc_wr)
                             ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
        cmdHeader_d.addr = reqHeader.addr;
        cmdHeader_d.size = reqHeader.size;
        cmdHeader_d.payload.lce_id = reqHeader.payload.src_id;

        lceCmdHeader_d = '0;
        lceCmdHeader_d.msg_type = (respHeader.msg_type == e_bedrock_mem_uc_wr)
                                ? e_bedrock_cmd_uc_st_done : e_bedrock_cmd_uc_data;
        lceCmdHeader_d.addr = respHeader.addr;
        lceCmdHeader_d.size = respHeader.size;
        lceCmdHeader_d.payload.dst_id = respHeader.payload.lce_id;
        lceCmdHeader_d.payload.src_id = cce_id_i;
    end

    // Slot contents are captured only when the slot is loaded.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmdHeader_q    <= '0;
            cmdData_q      <= '0;
            lceCmdHeader_q <= '0;
            lceCmdData_q   <= '0;
        end else begin
            if (cmdLoad) begin
                cmdHeader_q <= cmdHeader_d;
                cmdData_q   <= lce_req_data_i;
            end
            if (respLoad) begin
                lceCmdHeader_q <= lceCmdHeader_d;
                lceCmdData_q   <= io_resp_data_i;
            end
        end
    end

    // Credits rise with each I/O command issued and fall with each LCE command delivered.
    always_comb begin
        credit_d = credit_q;
        if (cmdLoad && !respDrain) begin
            credit_d = credit_q + oneCreditLp;
        end else if (!cmdLoad && respDrain) begin
            credit_d = credit_q - oneCreditLp;
        end
    end

    // Credit counter and the registered drop indication.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credit_q <= '0;
            error_q  <= 1'b0;
        end else begin
            credit_q <= credit_d;
            error_q  <= errorEvent;
        end
    end

endmodule

// File: tb/tb_bp_io_lce_responder.sv
// Directed bench for bp_io_lce_responder with a scoreboard on both output paths.
module tb_bp_io_lce_responder;

    localparam int ElsP = 2;

    localparam logic [3:0] ReqRd     = 4'd0;
    localparam logic [3:0] ReqUcRd   = 4'd2;
    localparam logic [3:0] ReqUcWr   = 4'd3;
    localparam logic [3:0] MemUcRd   = 4'd2;
    localparam logic [3:0] MemUcWr   = 4'd3;
    localparam logic [3:0] CmdUcData = 4'd7;
    localparam logic [3:0] CmdStDone = 4'd8;
    localparam logic [2:0] Size8     = 3'd3;

    typedef struct packed {
        logic [5:0] dst_id;
        logic [5:0] src_id;
    } reqPayload_t;
    typedef struct packed {
        reqPayload_t payload;
        logic [2:0]  size;
        logic [39:0] addr;
        logic [3:0]  msg_type;
    } reqHeader_t;
    typedef struct packed {
        logic [5:0] lce_id;
        logic [2:0] way_id;
        logic [2:0] state;
    } memPayload_t;
    typedef struct packed {
        memPayload_t payload;
        logic [2:0]  size;
        logic [39:0] addr;
        logic [3:0]  subop;
        logic [3:0]  msg_type;
    } memHeader_t;
    typedef struct packed {
        logic [5:0] dst_id;
        logic [5:0] src_id;
        logic [2:0] way_id;
        logic [2:0] state;
    } cmdPayload_t;
    typedef struct packed {
        cmdPayload_t payload;
        logic [2:0]  size;
        logic [39:0] addr;
        logic [3:0]  msg_type;
    } cmdHeader_t;

    typedef struct { memHeader_t h; logic [63:0] d; } ioExp_t;
    typedef struct { cmdHeader_t h; logic [63:0] d; } lceExp_t;

    logic clock;
    logic resetN;
    logic [5:0] cceId;
    reqHeader_t reqHeader;
    logic [63:0] reqData;
    logic reqV, reqYumi;
    memHeader_t ioCmdHeader;
    logic [63:0] ioCmdData;
    logic ioCmdV, ioCmdLast, ioCmdReady;
    memHeader_t respHeader;
    logic [63:0] respData;
    logic respV, respLast, respYumi;
    cmdHeader_t lceCmdHeader;
    logic [63:0] lceCmdData;
    logic lceCmdV, lceCmdReady;
    logic errorOut;

    ioExp_t ioQ[$];
    lceExp_t lceQ[$];
    ioExp_t ioE;
    lceExp_t lceE;
    memHeader_t heldHeader;

    int checks = 0;
    int fails = 0;
    int errPulses = 0;
    int expErr = 0;

    bp_io_lce_responder #(.els_p(ElsP)) dut (
        .clk_i              (clock),
        .reset_n_i          (resetN),
        .cce_id_i           (cceId),
        .lce_req_header_i   (reqHeader),
        .lce_req_data_i     (reqData),
        .lce_req_v_i        (reqV),
        .lce_req_yumi_o     (reqYumi),
        .io_cmd_header_o    (ioCmdHeader),
        .io_cmd_data_o      (ioCmdData),
        .io_cmd_v_o         (ioCmdV),
        .io_cmd_last_o      (ioCmdLast),
        .io_cmd_ready_and_i (ioCmdReady),
        .io_resp_header_i   (respHeader),
        .io_resp_data_i     (respData),
        .io_resp_v_i        (respV),
        .io_resp_last_i     (respLast),
        .io_resp_yumi_o     (respYumi),
        .lce_cmd_header_o   (lceCmdHeader),
        .lce_cmd_data_o     (lceCmdData),
        .lce_cmd_v_o        (lceCmdV),
        .lce_cmd_ready_and_i(lceCmdReady),
        .error_o            (errorOut)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic memHeader_t modelIoCmd(input reqHeader_t r);
        memHeader_t m;
        m = '0;
        m.msg_type = (r.msg_type == ReqUcWr) ? MemUcWr : MemUcRd;
        m.addr = r.addr;
        m.size = r.size;
        m.payload.lce_id = r.payload.src_id;
        return m;
    endfunction

    function automatic cmdHeader_t modelLceCmd(input memHeader_t m, input logic [5:0] cce);
        cmdHeader_t c;
        c = '0;
        c.msg_type = (m.msg_type == MemUcWr) ? CmdStDone : CmdUcData;
        c.addr = m.addr;
        c.size = m.size;
        c.payload.dst_id = m.payload.lce_id;
        c.payload.src_id = cce;
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request and check whether it is consumed this cycle.
    task automatic applyStimulus(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                                 input logic [5:0] src, input logic [63:0] d, input logic expYumi);
        reqHeader_t h;
        ioExp_t e;
        h = '0;
        h.msg_type = t;
        h.addr = a;
        h.size = s;
        h.payload.src_id = src;
        h.payload.dst_id = 6'd1;
        reqHeader = h;
        reqData = d;
        reqV = 1'b1;
        #1;
        checkOutput("req_yumi", reqYumi, expYumi);
        if (expYumi) begin
            if (t == ReqUcRd || t == ReqUcWr) begin
                e.h = modelIoCmd(h);
                e.d = d;
                ioQ.push_back(e);
            end else begin
                expErr++;
            end
        end
    endtask

    // Present an I/O response; expLoad says whether a credit is outstanding for it.
    task automatic applyResponse(input logic [3:0] t, input logic [5:0] lce, input logic [39:0] a,
                                 input logic [2:0] s, input logic [63:0] d,
                                 input logic expYumi, input logic expLoad);
        memHeader_t h;
        lceExp_t e;
        h = '0;
        h.msg_type = t;
        h.addr = a;
        h.size = s;
        h.payload.lce_id = lce;
        h.payload.way_id = 3'd5;
        respHeader = h;
        respData = d;
        respV = 1'b1;
        #1;
        checkOutput("resp_yumi", respYumi, expYumi);
        if (expYumi) begin
            if (expLoad) begin
                e.h = modelLceCmd(h, cceId);
                e.d = d;
                lceQ.push_back(e);
            end else begin
                expErr++;
            end
        end
    endtask

    // Scoreboard: compare every handshake on either output path with the oldest expectation.
    always @(negedge clock) begin
        if (resetN) begin
            if (errorOut) errPulses++;
            if (ioCmdV) checkOutput("io_cmd_last", ioCmdLast, 1'b1);
            if (ioCmdV && ioCmdReady) begin
                checkOutput("io_cmd_expected", ioQ.size() != 0, 1'b1);
                if (ioQ.size() != 0) begin
                    ioE = ioQ.pop_front();
                    checkOutput("io_cmd_header", ioCmdHeader, ioE.h);
                    checkOutput("io_cmd_data", ioCmdData, ioE.d);
                end
            end
            if (lceCmdV && lceCmdReady) begin
                checkOutput("lce_cmd_expected", lceQ.size() != 0, 1'b1);
                if (lceQ.size() != 0) begin
                    lceE = lceQ.pop_front();
                    checkOutput("lce_cmd_header", lceCmdHeader, lceE.h);
                    checkOutput("lce_cmd_data", lceCmdData, lceE.d);
                end
            end
        end
    end

    initial begin
        resetN = 1'b0;
        cceId = 6'd1;
        reqHeader = '0;
        reqData = '0;
        reqV = 1'b1;
        ioCmdReady = 1'b1;
        respHeader = '0;
        respData = '0;
        respV = 1'b1;
        respLast = 1'b1;
        lceCmdReady = 1'b1;
        #3;
        checkOutput("rst_io_cmd_v", ioCmdV, 1'b0);
        checkOutput("rst_lce_cmd_v", lceCmdV, 1'b0);
        checkOutput("rst_req_yumi", reqYumi, 1'b0);
        checkOutput("rst_resp_yumi", respYumi, 1'b0);
        checkOutput("rst_error", errorOut, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reqV = 1'b0;
        respV = 1'b0;
        resetN = 1'b1;

        $display("[TB] basic uncached read and store-done");
        applyStimulus(ReqUcRd, 40'h80_0000_0040, Size8, 6'd3, 64'hDEAD_BEEF_0000_0001, 1'b1);
        tick();
        reqV = 1'b0;
        checkOutput("uc_rd_io_cmd_v", ioCmdV, 1'b1);
        checkOutput("uc_rd_io_cmd_last", ioCmdLast, 1'b1);
        tick();
        applyResponse(MemUcWr, 6'd3, 40'h80_0000_0040, Size8, 64'h1111_2222_3333_4444, 1'b1, 1'b1);
        tick();
        respV = 1'b0;
        checkOutput("st_done_lce_cmd_v", lceCmdV, 1'b1);
        tick();
        checkOutput("st_done_drained", lceCmdV, 1'b0);

        $display("[TB] uncached write and data return");
        applyStimulus(ReqUcWr, 40'h00_0000_1000, 3'd2, 6'd5, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
        tick();
        reqV = 1'b0;
        tick();
        applyResponse(MemUcRd, 6'd5, 40'h00_0000_1000, 3'd2, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
        tick();
        respV = 1'b0;
        tick();

        $display("[TB] backpressure on io_cmd");
        ioCmdReady = 1'b0;
        applyStimulus(ReqUcRd, 40'h00_0000_2000, Size8, 6'd2, 64'h2222_0000_0000_0002, 1'b1);
        heldHeader = ioQ[ioQ.size()-1].h;
        tick();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ReqUcWr, 40'h00_0000_3000, Size8, 6'd4, 64'h4444_0000_0000_0004, 1'b0);
            checkOutput("stall_io_cmd_v", ioCmdV, 1'b1);
            checkOutput("stall_io_cmd_header", ioCmdHeader, heldHeader);
            tick();
        end
        ioCmdReady = 1'b1;
        applyStimulus(ReqUcWr, 40'h00_0000_3000, Size8, 6'd4, 64'h4444_0000_0000_0004, 1'b1);
        tick();
        reqV = 1'b0;
        checkOutput("second_io_cmd_v", ioCmdV, 1'b1);
        tick();
        applyResponse(MemUcRd, 6'd2, 40'h00_0000_2000, Size8, 64'h5555_0000_0000_0005, 1'b1, 1'b1);
        tick();
        applyResponse(MemUcWr, 6'd4, 40'h00_0000_3000, Size8, 64'h6666_0000_0000_0006, 1'b1, 1'b1);
        tick();
        respV = 1'b0;
        tick();

        $display("[TB] credit limit");
        applyStimulus(ReqUcRd, 40'h00_0000_4000, Size8, 6'd1, 64'h7000_0000_0000_0001, 1'b1);
        tick();
        applyStimulus(ReqUcRd, 40'h00_0000_4040, Size8, 6'd2, 64'h7000_0000_0000_0002, 1'b1);
        tick();
        applyStimulus(ReqUcRd, 40'h00_0000_4080, Size8, 6'd6, 64'h7000_0000_0000_0003, 1'b0);
        tick();
        checkOutput("limit_req_stall", reqYumi, 1'b0);
        tick();
        applyResponse(MemUcWr, 6'd1, 40'h00_0000_4000, Size8, 64'h8000_0000_0000_0001, 1'b1, 1'b1);
        checkOutput("limit_req_stall_resp", reqYumi, 1'b0);
        tick();
        respV = 1'b0;
        checkOutput("limit_lce_cmd_v", lceCmdV, 1'b1);
        applyStimulus(ReqUcRd, 40'h00_0000_4080, Size8, 6'd6, 64'h7000_0000_0000_0003, 1'b1);
        tick();
        reqV = 1'b0;
        applyResponse(MemUcRd, 6'd2, 40'h00_0000_4040, Size8, 64'h8000_0000_0000_0002, 1'b1, 1'b1);
        tick();
        applyResponse(MemUcRd, 6'd6, 40'h00_0000_4080, Size8, 64'h8000_0000_0000_0003, 1'b1, 1'b1);
        tick();
        respV = 1'b0;
        tick();

        $display("[TB] dropped messages");
        applyStimulus(ReqRd, 40'h00_0000_5000, Size8, 6'd3, 64'h9000_0000_0000_0001, 1'b1);
        tick();
        reqV = 1'b0;
        checkOutput("bad_req_error", errorOut, 1'b1);
        checkOutput("bad_req_no_io_cmd", ioCmdV, 1'b0);
        tick();
        checkOutput("bad_req_error_once", errorOut, 1'b0);
        applyResponse(MemUcRd, 6'd3, 40'h00_0000_5000, Size8, 64'h9000_0000_0000_0002, 1'b1, 1'b0);
        tick();
        respV = 1'b0;
        checkOutput("stray_resp_error", errorOut, 1'b1);
        checkOutput("stray_resp_no_lce_cmd", lceCmdV, 1'b0);
        tick();

        $display("[TB] reset with both slots full");
        ioCmdReady = 1'b0;
        lceCmdReady = 1'b0;
        applyStimulus(ReqUcRd, 40'h00_0000_6000, Size8, 6'd3, 64'hA000_0000_0000_0001, 1'b1);
        tick();
        reqV = 1'b0;
        applyResponse(MemUcRd, 6'd3, 40'h00_0000_6000, Size8, 64'hA000_0000_0000_0002, 1'b1, 1'b1);
        tick();
        respV = 1'b0;
        #1;
        checkOutput("pre_rst_io_cmd_v", ioCmdV, 1'b1);
        checkOutput("pre_rst_lce_cmd_v", lceCmdV, 1'b1);
        resetN = 1'b0;
        #1;
        checkOutput("async_rst_io_cmd_v", ioCmdV, 1'b0);
        checkOutput("async_rst_lce_cmd_v", lceCmdV, 1'b0);
        checkOutput("async_rst_error", errorOut, 1'b0);
        ioQ.delete();
        lceQ.delete();
        tick();
        tick();
        resetN = 1'b1;
        ioCmdReady = 1'b1;
        lceCmdReady = 1'b1;
        applyResponse(MemUcWr, 6'd3, 40'h00_0000_6000, Size8, 64'hA000_0000_0000_0003, 1'b1, 1'b0);
        tick();
        respV = 1'b0;
        checkOutput("post_rst_no_credit", errorOut, 1'b1);
        tick();
        applyStimulus(ReqUcWr, 40'h00_0000_7000, 3'd1, 6'd7, 64'hB000_0000_0000_0001, 1'b1);
        tick();
        reqV = 1'b0;
        tick();
        applyResponse(MemUcWr, 6'd7, 40'h00_0000_7000, 3'd1, 64'hB000_0000_0000_0002, 1'b1, 1'b1);
        tick();
        respV = 1'b0;
        tick();
        tick();

        checkOutput("error_pulse_count", errPulses, expErr);
        checkOutput("io_cmd_all_seen", ioQ.size(), 0);
        checkOutput("lce_cmd_all_seen", lceQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
